simt_alu_bank: RTL



---
 rtl/simt_alu_bank_if.sv | 33 +++
 rtl/simt_alu_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/simt_alu_bank_if.sv
// Operation/result bus of the SIMT ALU bank: an input valid/ready channel
// carrying opcode and lane operands, and an output valid/ready channel
// carrying lane results, flags and the consumed-result counter.
interface simt_alu_bank_if #(
  parameter int LANES = 32,
  parameter int WIDTH = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               op;
  logic                     sat;
  logic [LANES-1:0]         lane_mask;
  logic [LANES*WIDTH-1:0]   a_flat;
  logic [LANES*WIDTH-1:0]   b_flat;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   res_flat;
  logic [LANES-1:0]         ovf_mask;
  logic [LANES-1:0]         res_mask;
  logic [31:0]              op_count;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, op, sat, lane_mask, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, res_flat, ovf_mask, res_mask, op_count
  );

  // The ALU bank itself.
  modport slave (
    input  in_valid, op, sat, lane_mask, a_flat, b_flat, out_ready,
    output in_ready, out_valid, res_flat, ovf_mask, res_mask, op_count
  );
endinterface

// File: rtl/simt_alu_bank.sv
// SIMT ALU bank: LANES independent WIDTH-bit ALUs sharing one opcode,
// followed by a STAGES-deep elastic pipeline. Each stage has its own valid
// bit so bubbles collapse under backpressure, and the final stage drives
// the result outputs directly.
module simt_alu_bank #(
  parameter int LANES  = 32,
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  simt_alu_bank_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MIN   = 3'd2,
    OP_MAX   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  // One pipeline slot: lane results, overflow flags and the lane mask.
  typedef struct packed {
    logic [LANES*WIDTH-1:0] res;
    logic [LANES-1:0]       ovf;
    logic [LANES-1:0]       msk;
  } stage_t;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Single lane ALU; returns {ovf, result}. Overflow is only ever raised by
  // ADD/SUB, so saturation never touches the other opcodes.
  function automatic logic [WIDTH:0] lane_op(
    input logic [2:0]       op,
    input logic             sat,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    logic             ovf;
    r   = '0;
    ovf = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        r   = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r   = a - b;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MIN:   r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:   r = ($signed(a) > $signed(b)) ? a : b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_PASSA: r = a;
      default:  r = a;
    endcase
    // The sign of operand A tells which way the result overflowed.
    if (ovf && sat) r = a[WIDTH-1] ? SMIN : SMAX;
    return {ovf, r};
  endfunction

  stage_t              calc;
  stage_t              data_q [STAGES];
  logic [STAGES-1:0]   v_q;
  logic [STAGES-1:0]   move;
  logic [STAGES-1:0]   take;
  logic [STAGES-1:0]   load;
  logic                free;
  logic                in_fire;
  logic                out_fire;
  logic [31:0]         count_q;

  // Lane results computed combinationally from the presented operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    calc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_mask[i]) begin
        {calc.ovf[i], calc.res[i*WIDTH +: WIDTH]} =
          lane_op(bus.op, bus.sat, bus.a_flat[i*WIDTH +: WIDTH],
                  bus.b_flat[i*WIDTH +: WIDTH]);
      end
    end
    calc.msk = bus.lane_mask;
  end

  // Handshake chain from the output backwards: a stage moves when it is
  // valid and the slot downstream frees up; a stage can take new data when
  // it is empty or moving, which is how empty middle stages fill during a
  // stall.
  always_comb begin
    move = '0;
    take = '0;
    free = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      move[i] = v_q[i] && free;
      take[i] = !v_q[i] || move[i];
      free    = take[i];
    end
  end

  assign bus.in_ready  = rst_n && take[0];
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = move[STAGES-1];
  assign bus.out_valid = v_q[STAGES-1];

  // Per-stage load strobes: stage 0 from an input transfer, others from
  // the stage above moving down.
  always_comb begin
    load    = '0;
    load[0] = in_fire;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = move[i-1];
    end
  end

  // Stage valid bits and payload registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so each stage
    // samples its neighbour's pre-edge value and the shift stays ordered.
    if (!rst_n) begin
      v_q <= '0;
      // NOTE: payload registers are reset as well because the last stage
      // drives the result outputs directly and those must read 0 after reset.
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i])      v_q[i] <= 1'b1;
        else if (move[i]) v_q[i] <= 1'b0;
      end
      if (load[0]) data_q[0] <= calc;
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) data_q[i] <= data_q[i-1];
      end
    end
  end

  // Consumed-result counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_fire && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.res_flat = data_q[STAGES-1].res;
  assign bus.ovf_mask = data_q[STAGES-1].ovf;
  assign bus.res_mask = data_q[STAGES-1].msk;
  assign bus.op_count = count_q;

endmodule
